// File: rtl/result_collector_pkg.sv
// Shared parameters, FSM encoding and helpers for the result collector.
package result_collector_pkg;

   localparam int R_WIDTH = 20;
   localparam int DEPTH   = 64;
   localparam int ITR     = 64;
   localparam int LIMIT   = 970200;
   localparam int IDX_W   = 6;
   localparam int CNT_W   = 7;
   localparam int SUM_W   = 26;
   localparam int ENTRY_W = IDX_W + R_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_COLLECT = 2'b01,
      S_DRAIN   = 2'b10
   } state_t;

   // A result at or above the search ceiling means the engine found no answer.
   function automatic logic is_miss(input logic [R_WIDTH-1:0] value);
      return SUM_W'(value) >= SUM_W'(LIMIT);
   endfunction

endpackage

// File: rtl/result_collector_if.sv
// Result strobe input and host drain port of the result collector.
interface result_collector_if;
   import result_collector_pkg::*;

   logic               in_done;
   logic [R_WIDTH-1:0] in_result;
   logic               out_valid;
   logic               out_ready;
   logic [R_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]   out_idx;

   // Producer/host side: drives the strobe and the ready.
   modport master (
      output in_done, in_result, out_ready,
      input  out_valid, out_data, out_idx
   );

   // Collector side.
   modport slave (
      input  in_done, in_result, out_ready,
      output out_valid, out_data, out_idx
   );
endinterface

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO; the head entry is always visible on rd_data.
module result_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   // Empty FIFO presents zero rather than stale storage.
   assign rd_data = empty ? '0 : mem[rd_ptr_reg];

   // Storage write; contents need no reset because pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr_reg] <= wr_data;
   end

   // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/result_collector.sv
// Collects engine results into a tagged FIFO, tracks per-batch statistics
// and signals when a full batch has been captured and must be drained.
module result_collector
   import result_collector_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   result_collector_if.slave  bus,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               overflow,
   output logic               batch_done,
   output logic [SUM_W-1:0]   sum,
   output logic [R_WIDTH-1:0] min_result,
   output logic [R_WIDTH-1:0] max_result,
   output logic [CNT_W-1:0]   miss_cnt
);
   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic               push_ok;
   logic               pop_ok;
   logic               drain_empty;
   logic               stats_reset;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head;

   // Full comes from registered occupancy, so a same-cycle pop never rescues a push.
   assign push_ok     = bus.in_done & (state_reg != S_DRAIN) & ~full;
   assign pop_ok      = bus.out_valid & bus.out_ready;
   assign drain_empty = (count == '0) || (count == CNT_W'(1) && pop_ok);
   assign stats_reset = (state_reg == S_DRAIN) && (state_next == S_IDLE);

   assign bus.out_valid = ~fifo_empty;
   assign bus.out_idx   = head[ENTRY_W-1:R_WIDTH];
   assign bus.out_data  = head[R_WIDTH-1:0];
   assign batch_done    = (state_reg == S_DRAIN);

   result_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push    (push_ok),
      .pop     (pop_ok),
      .wr_data ({idx_reg, bus.in_result}),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (fifo_empty)
   );

   // Batch sequencing: collect ITR results, then hold until the host drains them.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_COLLECT: begin
            if (push_ok)
               state_next = (idx_reg == IDX_W'(ITR-1)) ? S_DRAIN : S_COLLECT;
         end
         S_DRAIN: begin
            if (drain_empty) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state_reg <= S_IDLE;
      else if (clear) state_reg <= S_IDLE;
      else            state_reg <= state_next;
   end

   // Sequence index of the next accepted result, restarting every batch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       idx_reg <= '0;
      else if (clear)   idx_reg <= '0;
      else if (push_ok) idx_reg <= (idx_reg == IDX_W'(ITR-1)) ? '0 : idx_reg + 1'b1;
   end

   // Running statistics, restarted when a drained batch returns to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum        <= '0;
         min_result <= '1;
         max_result <= '0;
         miss_cnt   <= '0;
      end else if (clear || stats_reset) begin
         sum        <= '0;
         min_result <= '1;
         max_result <= '0;
         miss_cnt   <= '0;
      end else if (push_ok) begin
         sum <= sum + SUM_W'(bus.in_result);
         if (bus.in_result < min_result) min_result <= bus.in_result;
         if (bus.in_result > max_result) max_result <= bus.in_result;
         if (is_miss(bus.in_result))     miss_cnt   <= miss_cnt + 1'b1;
      end
   end

   // Sticky flag for any strobe that could not be stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        overflow <= 1'b0;
      else if (clear)                    overflow <= 1'b0;
      else if (bus.in_done && !push_ok)  overflow <= 1'b1;
   end
endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream consumer of the divisor-search engine's per-iteration result stream. Captures each 20-bit Result qualified by the single-cycle Done pulse.
- Buffers captured results in a DEPTH-entry FIFO tagged with a sequence index, and keeps running statistics (sum, min, max, no-answer count).
- Drains entries to a host through a valid/ready port. Signals batch completion after ITR results have been accepted.

Parameters:
- R_WIDTH, 20, result width
- DEPTH, 64, FIFO entries (power of 2)
- ITR, 64, results per batch
- LIMIT, 970200, search ceiling; a result >= LIMIT is a "no answer"

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- Clear  in  1  synchronous soft clear; same effect as reset except it is clocked
- In_done  in  1  single-cycle result strobe from the search engine
- In_result  in  R_WIDTH  result value, sampled when In_done=1
- Out_valid  out  1  FIFO head available
- Out_ready  in  1  host accepts head
- Out_data  out  R_WIDTH  head result
- Out_idx  out  6  head sequence index, 0..ITR-1
- Count  out  7  FIFO occupancy, 0..64
- Full  out  1  Count==DEPTH
- Overflow  out  1  sticky; set when an In_done strobe is dropped
- Batch_done  out  1  level; ITR results accepted in the current batch
- Sum  out  26  sum of accepted results; 64*970200 < 2^26, so the sum cannot wrap
- Min_result  out  R_WIDTH  minimum accepted result
- Max_result  out  R_WIDTH  maximum accepted result
- Miss_cnt  out  7  accepted results that are >= LIMIT

Behaviour:
- Reset (Rst=0, asynchronous) or Clear=1 (next edge):
  - FSM goes to S_IDLE.
  - FIFO pointers are set to 0, so Count=0 and Out_valid=0.
  - Out_data=0, Out_idx=0, Sum=0, Min_result=all-ones, Max_result=0, Miss_cnt=0.
  - Overflow=0, Batch_done=0, write index=0.
  - Reset or Clear mid-batch discards all buffered data. Clear takes priority over same-cycle In_done and pop.
- Push:
  - Accepted when In_done=1, the state is S_IDLE or S_COLLECT, and Full=0 as registered at the start of that cycle.
  - A push while Full is dropped even if a pop occurs in the same cycle.
  - A dropped strobe sets Overflow, which stays set until Clear or reset.
- Accepted push:
  - Write {idx, In_result} at wr_ptr.
  - Increment the 6-bit idx.
  - Add to Sum, update Min_result and Max_result, and increment Miss_cnt if In_result >= LIMIT.
  - All statistics are visible the cycle after the strobe.
- Pop:
  - Occurs on Out_valid & Out_ready.
  - Out_data and Out_idx are a show-ahead read of the head entry.
  - Out_valid = (Count != 0). A pushed entry appears on Out_valid exactly 1 cycle after its In_done edge.
- Simultaneous accepted push and pop: Count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count is 7 bits so that full and empty are distinguishable.
- FSM:
  - S_IDLE:
    - Batch_done=0.
    - An accepted push moves to S_COLLECT.
  - S_COLLECT:
    - Accepts pushes.
    - When the ITR-th push of the batch is accepted (idx wraps 63->0), moves to S_DRAIN; Batch_done=1 from the next cycle.
  - S_DRAIN:
    - Batch_done=1.
    - In_done strobes are dropped and set Overflow.
    - When Count reaches 0 (including the cycle the last pop completes), moves to S_IDLE.
    - On entering S_IDLE, Batch_done clears and Sum, Min_result, Max_result and Miss_cnt reset for the next batch.
  - Statistics remain stable and readable throughout S_DRAIN.
- Out_ready while Out_valid=0 has no effect.
- In_result is ignored when In_done=0.

Decomposition:
- Shared package holds:
  - R_WIDTH, DEPTH, ITR, LIMIT.
  - IDX_W=6, CNT_W=7, SUM_W=26.
  - FSM state encodings S_IDLE=2'b00, S_COLLECT=2'b01, S_DRAIN=2'b10.
- One sub-module, result_fifo:
  - Parameterized synchronous FIFO, (IDX_W+R_WIDTH) bits wide and DEPTH deep.
  - Show-ahead read; push, pop, count, full and empty.
  - Asynchronous active-low reset and synchronous clear.
- The top level holds the FSM, statistics registers and Overflow logic.

Test Plan:
- Single result:
  - Reset, then In_done pulse with In_result=12.
  - Next cycle: Out_valid=1, Out_data=12, Out_idx=0, Count=1, Sum=12, Min_result=12, Max_result=12, Miss_cnt=0.
  - Out_ready=1 for one cycle, then Count=0.
- Full batch:
  - 64 pulses with values 1..64, spaced 5 cycles, Out_ready=0.
  - Full=1, Batch_done=1, Sum=2080, Min_result=1, Max_result=64.
  - Drain 64 entries: Out_idx runs 0..63 in order, then Batch_done=0 and the FSM is in S_IDLE.
- Overflow in drain:
  - After a full batch, one extra In_done with value 7.
  - Overflow=1, Count stays 64, no entry added.
- Miss counting:
  - Results 970200, 970201, 5.
  - Miss_cnt=2, Max_result=970201, Min_result=5.
- Simultaneous push and pop:
  - With Count=3, assert In_done and Out_ready in the same cycle.
  - Count stays 3 and the head advances to the next Out_idx.
- Reset mid-batch:
  - After 10 pushes, pulse Rst low asynchronously between clock edges.
  - All outputs return to reset values immediately. A subsequent push gets Out_idx=0.
